// File: rtl/pio_pkg.sv
// Shared definitions for the PIO input block: register offsets and the
// encodings used by the EDGE_TYPE and IRQ_MODE parameters.
package pio_pkg;

  // Register offsets on the 2-bit address bus.
  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_RSVD    = 2'd1,
    REG_IRQMASK = 2'd2,
    REG_EDGECAP = 2'd3
  } reg_addr_e;

  // EDGE_TYPE encodings.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // IRQ_MODE encodings.
  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_debounce.sv
// Single-bit input conditioner: SYNC_STAGES-deep synchroniser followed by an
// optional debounce filter.
//   clk, reset : clock and synchronous active-high reset
//   d_i        : asynchronous external input bit
//   filt_o     : synchronised, debounced level
module pio_debounce
  import pio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic filt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE == 0) begin : g_bypass
    assign filt_o = sync;
  end else begin : g_filter
    localparam int              CW   = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]   CMAX = CW'(DEBOUNCE);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    // The counter tracks consecutive cycles where sync disagrees with the
    // filtered level. Once it has reached DEBOUNCE the new level is adopted
    // and the counter restarts, so a bounce straight after the update has to
    // qualify again rather than slipping through a saturated counter.
    always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      if (sync == filt_q) begin
        cnt_d = '0;
      end else if (cnt_q == CMAX) begin
        filt_d = sync;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

    assign filt_o = filt_q;
  end

endmodule

// File: rtl/pio_in_edge.sv
// Parallel input port with per-bit synchronisation, debounce, edge capture
// and interrupt generation, behind a 4-register slave interface.
//   clk, reset          : clock and synchronous active-high reset
//   address, chipselect : register select / slave select
//   write_n, writedata  : active-low write strobe and write data
//   in_port             : asynchronous external inputs (WIDTH bits)
//   readdata            : registered read data, one-cycle latency
//   irq                 : interrupt request (level or edge source)
// Registers: 0 data (RO), 1 reserved, 2 irqmask (RW), 3 edgecapture (W1C).
module pio_in_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] wr_clr;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             wr_en;
  reg_addr_e        addr;
  logic             unused_wdata;

  assign addr         = reg_addr_e'(address);
  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .d_i   (in_port[i]),
      .filt_o(filt[i])
    );
  end

  always_comb begin
    if (EDGE_TYPE == EDGE_FALL) begin
      det = ~filt & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      det = filt ^ prev_q;
    end else begin
      det = filt & ~prev_q;
    end
  end

  always_comb begin
    mask_d = mask_q;
    wr_clr = '0;
    if (wr_en) begin
      case (addr)
        REG_IRQMASK: mask_d = writedata[WIDTH-1:0];
        REG_EDGECAP: wr_clr = writedata[WIDTH-1:0];
        default:     ;
      endcase
    end
    // A fresh edge outranks a same-cycle clear of the same bit.
    ecap_d = (ecap_q & ~wr_clr) | det;
  end

  always_comb begin
    rdata_d = '0;
    case (addr)
      REG_DATA:    rdata_d[WIDTH-1:0] = filt;
      REG_IRQMASK: rdata_d[WIDTH-1:0] = mask_q;
      REG_EDGECAP: rdata_d[WIDTH-1:0] = ecap_q;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= '0;
      ecap_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      prev_q  <= filt;
      ecap_q  <= ecap_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = (IRQ_MODE == IRQ_LEVEL) ? |(filt & mask_q)
                                            : |(ecap_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge.sv
module tb_pio_in_edge;
  import pio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        cs0, cs1, cs2;
  logic [7:0]  in0, in1, in2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  always #5 clk = ~clk;

  // Default configuration: rising edge, edge-sourced irq.
  pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(4),
                .EDGE_TYPE(EDGE_RISE), .IRQ_MODE(IRQ_EDGE)) u_dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs0),
    .write_n(write_n), .writedata(writedata), .in_port(in0),
    .readdata(rd0), .irq(irq0));

  // Falling-edge capture.
  pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(4),
                .EDGE_TYPE(EDGE_FALL), .IRQ_MODE(IRQ_EDGE)) u_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs1),
    .write_n(write_n), .writedata(writedata), .in_port(in1),
    .readdata(rd1), .irq(irq1));

  // Level-sourced irq.
  pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE(4),
                .EDGE_TYPE(EDGE_RISE), .IRQ_MODE(IRQ_LEVEL)) u_lvl (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs2),
    .write_n(write_n), .writedata(writedata), .in_port(in2),
    .readdata(rd2), .irq(irq2));

  typedef struct {
    string       tag;
    int unsigned src;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Returns 1 ns after rising edge number k.
  task automatic wait_edge(input int unsigned k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input string tag, input int unsigned src, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.src = src;
    e.exp = exp;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int unsigned src);
    case (src)
      0:       return rd0;
      1:       return {31'b0, irq0};
      2:       return rd1;
      3:       return {31'b0, irq1};
      4:       return rd2;
      default: return {31'b0, irq2};
    endcase
  endfunction

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.src);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed 0x%08h expected 0x%08h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic expect_all_zero(input string tag);
    expect_val({tag, "_rd0"}, 0, 32'h0);
    expect_val({tag, "_irq0"}, 1, 32'h0);
    expect_val({tag, "_rd1"}, 2, 32'h0);
    expect_val({tag, "_irq1"}, 3, 32'h0);
    expect_val({tag, "_rd2"}, 4, 32'h0);
    expect_val({tag, "_irq2"}, 5, 32'h0);
  endtask

  initial begin
    #2000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; address = 2'd0; write_n = 1'b1; writedata = '0;
    cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
    in0 = '0; in1 = '0; in2 = '0;

    wait_edge(2);
    expect_all_zero("reset");
    drain();
    reset = 1'b0;

    // irqmask=0x01 on u_dut; u_fall's bit 2 goes high (rising edge ignored)
    wait_edge(3);
    in1 = 8'h04;
    cs0 = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h1;
    wait_edge(4);
    cs0 = 1'b0; write_n = 1'b1;
    expect_val("mask_readback", 0, 32'h1);
    wait_edge(5);
    drain();
    address = 2'd0;

    // Bit 0 rises, sampled at edge 10: filt at 16, capture at 17
    wait_edge(9);
    in0 = 8'h01;
    wait_edge(15);
    expect_val("data_before", 0, 32'h0);
    expect_val("irq_before", 1, 32'h0);
    drain();
    wait_edge(16);
    expect_val("cap_not_yet", 1, 32'h0);
    drain();
    wait_edge(17);
    expect_val("data_rise", 0, 32'h1);
    expect_val("irq_cap", 1, 32'h1);
    drain();
    address = 2'd3;
    wait_edge(18);
    expect_val("ecap_read", 0, 32'h1);
    drain();
    cs0 = 1'b1; write_n = 1'b0; writedata = 32'h1;
    wait_edge(19);
    cs0 = 1'b0; write_n = 1'b1;
    expect_val("w1c_irq", 1, 32'h0);
    drain();
    wait_edge(20);
    expect_val("w1c_ecap", 0, 32'h0);
    drain();

    // 3-cycle glitch on bit 3 with bit 3 unmasked
    in0 = 8'h09;
    cs0 = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h09;
    wait_edge(21);
    cs0 = 1'b0; write_n = 1'b1; address = 2'd3;
    wait_edge(23);
    in0 = 8'h01;
    wait_edge(24);
    expect_val("glitch_irq_a", 1, 32'h0);
    drain();
    wait_edge(27);
    expect_val("glitch_irq_b", 1, 32'h0);
    drain();
    wait_edge(30);
    expect_val("glitch_ecap", 0, 32'h0);
    expect_val("glitch_irq_c", 1, 32'h0);
    drain();
    address = 2'd0;
    wait_edge(31);
    expect_val("glitch_data", 0, 32'h1);
    drain();

    // Falling bit 0 must not capture in rising mode
    in0 = 8'h00;
    wait_edge(40);
    address = 2'd3;
    wait_edge(41);
    expect_val("fall_ignored", 0, 32'h0);
    drain();

    // u_fall: mask 0x04, then bit 2 falls
    wait_edge(42);
    cs1 = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h04;
    wait_edge(43);
    cs1 = 1'b0; write_n = 1'b1;
    expect_val("fall_rise_ignored", 3, 32'h0);
    drain();
    wait_edge(44);
    expect_val("fall_mask_rb", 2, 32'h04);
    drain();
    in1 = 8'h00;
    in0 = 8'h10;
    address = 2'd0;
    wait_edge(51);
    expect_val("fall_irq_pre", 3, 32'h0);
    drain();
    wait_edge(52);
    expect_val("fall_irq_set", 3, 32'h1);
    drain();
    wait_edge(53);
    expect_val("fall_irq_hold", 3, 32'h1);
    drain();
    cs1 = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h04;
    wait_edge(54);
    cs1 = 1'b0; write_n = 1'b1;
    expect_val("fall_irq_clr", 3, 32'h0);
    drain();

    // u_dut: bit 4 already captured; bit 1 edge coincides with W1C of 0x12
    wait_edge(55);
    in0 = 8'h12;
    wait_edge(61);
    address = 2'd3;
    wait_edge(62);
    expect_val("ecap_pre", 0, 32'h10);
    drain();
    cs0 = 1'b1; write_n = 1'b0; writedata = 32'h12;
    wait_edge(63);
    cs0 = 1'b0; write_n = 1'b1;
    expect_val("ecap_at_write", 0, 32'h10);
    drain();
    wait_edge(64);
    expect_val("set_wins", 0, 32'h02);
    drain();

    // u_lvl: level irq follows filt bit 7
    cs2 = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h80;
    wait_edge(65);
    cs2 = 1'b0; write_n = 1'b1; address = 2'd0;
    in2 = 8'h80;
    wait_edge(71);
    expect_val("lvl_pre", 5, 32'h0);
    drain();
    wait_edge(72);
    expect_val("lvl_high", 5, 32'h1);
    drain();
    wait_edge(73);
    expect_val("lvl_data", 4, 32'h80);
    drain();
    in2 = 8'h00;
    wait_edge(79);
    expect_val("lvl_hold", 5, 32'h1);
    drain();
    wait_edge(80);
    expect_val("lvl_low", 5, 32'h0);
    drain();

    // Rise again, reset mid-debounce
    in2 = 8'h80;
    wait_edge(84);
    reset = 1'b1;
    wait_edge(85);
    expect_all_zero("mid_reset");
    drain();
    reset = 1'b0;
    address = 2'd2;
    wait_edge(86);
    expect_val("rst_rd_next", 4, 32'h0);
    expect_val("rst_mask_clear", 0, 32'h0);
    expect_val("rst_irq_next", 5, 32'h0);
    drain();
    address = 2'd3;

    // Inputs held high through reset produce one rising capture
    wait_edge(93);
    expect_val("post_rst_pre", 0, 32'h0);
    drain();
    wait_edge(94);
    expect_val("post_rst_cap", 0, 32'h12);
    expect_val("post_rst_irq", 5, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
